// File: rtl/alu_defs.sv
// Shared encodings for the multi-cycle ALU: opcodes, shift sub-ops and FSM states.
package alu_defs;

  typedef enum logic [2:0] {
    OP_FWD   = 3'b000,
    OP_ADD   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_SHIFT = 3'b100,
    OP_MUL   = 3'b101,
    OP_SUB   = 3'b110,
    OP_RSVD  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, one multiplier bit per step; keeps only the low WIDTH bits.
// product is the accumulator value after the current step; done flags the final step.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = (cnt_q == CW'(1));

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = CW'(WIDTH);
    end else if (step) begin
      acc_d    = product;
      mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU with start/busy/done handshake. Define ALU_FAST_SHIFT_EN to use a
// single-cycle barrel shifter; otherwise shifts iterate one bit position per cycle.
module multicycle_alu
  import alu_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       ALUOP,
  input  logic [1:0]       SHIFTOP,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             BUSY,
  output logic             DONE
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;

  logic             accept;
  alu_op_e          req_op;
  logic [SHW-1:0]   req_amt;
  logic [WIDTH:0]   add_sum;

  logic             mul_load, mul_step, mul_last;
  logic [WIDTH-1:0] mul_product;

`ifdef ALU_FAST_SHIFT_EN
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] v,
                                              input logic [SHW-1:0]   n,
                                              input shift_op_e        s);
    logic [2*WIDTH-1:0] rot;
    rot = {v, v} >> n;
    case (s)
      SH_SLL:  barrel = v << n;
      SH_SRL:  barrel = v >> n;
      SH_SRA:  barrel = WIDTH'($signed(v) >>> n);
      default: barrel = rot[WIDTH-1:0];
    endcase
  endfunction
`else
  shift_op_e        shop_q, shop_d;
  logic [WIDTH-1:0] sh_q, sh_d;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input shift_op_e        s);
    case (s)
      SH_SLL:  shift1 = {v[WIDTH-2:0], 1'b0};
      SH_SRL:  shift1 = {1'b0, v[WIDTH-1:1]};
      SH_SRA:  shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
      default: shift1 = {v[0], v[WIDTH-1:1]};
    endcase
  endfunction
`endif

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (CLK),
    .srst    (RESET),
    .load    (mul_load),
    .step    (mul_step),
    .a       (DATA1),
    .b       (DATA2),
    .product (mul_product),
    .done    (mul_last)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
    shop_d   = shop_q;
    sh_d     = sh_q;
`endif
    req_op   = alu_op_e'(ALUOP);
    req_amt  = DATA2[SHW-1:0];
    add_sum  = {1'b0, DATA1} + {1'b0, DATA2};
    accept   = START && (state_q != ST_RUN);

    case (state_q)
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_MUL) begin
          mul_step = 1'b1;
          if (mul_last) begin
            state_d  = ST_FIN;
            result_d = mul_product;
            carry_d  = 1'b0;
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        else begin
          sh_d = shift1(sh_q, shop_q);
          if (cnt_q == CW'(1)) begin
            state_d  = ST_FIN;
            result_d = sh_d;
            carry_d  = 1'b0;
          end
        end
`endif
      end
      ST_FIN:  state_d = ST_IDLE;
      default: ;
    endcase

    // FIN accepts a new request too, which gives back-to-back issue.
    if (accept) begin
      op_d    = req_op;
      state_d = ST_FIN;
      case (req_op)
        OP_FWD: begin
          result_d = DATA2;
          carry_d  = 1'b0;
        end
        OP_ADD: begin
          result_d = add_sum[WIDTH-1:0];
          carry_d  = add_sum[WIDTH];
        end
        OP_AND: begin
          result_d = DATA1 & DATA2;
          carry_d  = 1'b0;
        end
        OP_OR: begin
          result_d = DATA1 | DATA2;
          carry_d  = 1'b0;
        end
        OP_SUB: begin
          result_d = DATA1 - DATA2;
          carry_d  = (DATA1 >= DATA2);
        end
        OP_MUL: begin
          mul_load = 1'b1;
          cnt_d    = CW'(WIDTH);
          state_d  = ST_RUN;
        end
        OP_SHIFT: begin
`ifdef ALU_FAST_SHIFT_EN
          result_d = barrel(DATA1, req_amt, shift_op_e'(SHIFTOP));
          carry_d  = 1'b0;
`else
          shop_d = shift_op_e'(SHIFTOP);
          sh_d   = DATA1;
          if (req_amt == '0) begin
            result_d = DATA1;
            carry_d  = 1'b0;
          end else begin
            cnt_d   = CW'(req_amt);
            state_d = ST_RUN;
          end
`endif
        end
        default: begin
          result_d = '0;
          carry_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_FWD;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

`ifndef ALU_FAST_SHIFT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shop_q <= SH_SLL;
      sh_q   <= '0;
    end else begin
      shop_q <= shop_d;
      sh_q   <= sh_d;
    end
  end
`endif

  assign RESULT = result_q;
  assign ZERO   = (result_q == '0);
  assign CARRY  = carry_q;
  assign BUSY   = (state_q == ST_RUN);
  assign DONE   = (state_q == ST_FIN);

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and random checks of multicycle_alu at WIDTH=8 with a queue-based scoreboard.
module tb_multicycle_alu;
  localparam int W = 8;
  localparam logic [2:0] A_FWD = 3'b000, A_ADD = 3'b001, A_AND = 3'b010, A_OR = 3'b011;
  localparam logic [2:0] A_SHF = 3'b100, A_MUL = 3'b101, A_SUB = 3'b110, A_RSV = 3'b111;
  localparam logic [1:0] S_SLL = 2'b00, S_SRL = 2'b01, S_SRA = 2'b10, S_ROR = 2'b11;

  logic         CLK = 1'b0;
  logic         RESET, START;
  logic [2:0]   ALUOP;
  logic [1:0]   SHIFTOP;
  logic [W-1:0] DATA1, DATA2, RESULT;
  logic         ZERO, CARRY, BUSY, DONE;

  typedef struct {
    logic [W-1:0] result;
    logic         carry;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .ALUOP  (ALUOP),
    .SHIFTOP(SHIFTOP),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .RESULT (RESULT),
    .ZERO   (ZERO),
    .CARRY  (CARRY),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] op, input logic [W-1:0] b);
    int n;
    n = int'(b[2:0]);
    if (op == A_MUL) return W + 1;
`ifdef ALU_FAST_SHIFT_EN
    if (op == A_SHF) return 1;
`else
    if (op == A_SHF) return (n == 0) ? 1 : n + 1;
`endif
    return 1;
  endfunction

  function automatic logic [W:0] model(input logic [2:0] op, input logic [1:0] sh,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]   r;
    logic           c;
    logic [2*W-1:0] wide;
    int             n;
    r = '0;
    c = 1'b0;
    n = int'(b[2:0]);
    case (op)
      A_FWD: r = b;
      A_ADD: {c, r} = {1'b0, a} + {1'b0, b};
      A_AND: r = a & b;
      A_OR:  r = a | b;
      A_SHF: begin
        case (sh)
          S_SLL:   r = a << n;
          S_SRL:   r = a >> n;
          S_SRA:   r = W'($signed(a) >>> n);
          default: begin
            wide = {a, a} >> n;
            r = wide[W-1:0];
          end
        endcase
      end
      A_MUL: begin
        wide = a * b;
        r = wide[W-1:0];
      end
      A_SUB: begin
        r = a - b;
        c = (a >= b);
      end
      default: r = '0;
    endcase
    return {c, r};
  endfunction

  // Caller sits at a falling edge; START is sampled on the next rising edge.
  task automatic issue(input logic [2:0] op, input logic [1:0] sh, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic ec);
    exp_t e;
    e.result = er;
    e.carry  = ec;
    e.lat    = lat_of(op, b);
    exp_q.push_back(e);
    ALUOP = op; SHIFTOP = sh; DATA1 = a; DATA2 = b; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; ALUOP = ~op; SHIFTOP = ~sh; DATA1 = ~a; DATA2 = ~b;
  endtask

  task automatic issue_model(input logic [2:0] op, input logic [1:0] sh,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] m;
    m = model(op, sh, a, b);
    issue(op, sh, a, b, m[W-1:0], m[W]);
  endtask

  task automatic wait_done(input bit noise, input string tag);
    int   cyc;
    int   busy_n;
    exp_t e;
    cyc = 1;
    busy_n = 0;
    while (DONE !== 1'b1 && cyc < 64) begin
      if (BUSY === 1'b1) busy_n++;
      if (noise) begin
        START = (cyc == 3 || cyc == 5);
        ALUOP = A_ADD; DATA1 = 8'h01; DATA2 = 8'h02;
      end
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0;
    e = exp_q.pop_front();
    check({tag, "/done"}, DONE, 1'b1);
    check({tag, "/latency"}, cyc, e.lat);
    check({tag, "/busy_cycles"}, busy_n, e.lat - 1);
    check({tag, "/busy_at_done"}, BUSY, 1'b0);
    check({tag, "/result"}, RESULT, e.result);
    check({tag, "/carry"}, CARRY, e.carry);
    check({tag, "/zero"}, ZERO, (e.result == '0));
    $display("[TB] %s: result=%02h carry=%0b zero=%0b done_cycle=%0d busy=%0d",
             tag, RESULT, CARRY, ZERO, cyc, busy_n);
  endtask

  initial begin
    exp_t e_drop;
    int   dn;
    RESET = 1'b1; START = 1'b0; ALUOP = '0; SHIFTOP = '0; DATA1 = '0; DATA2 = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("reset/result", RESULT, 8'h00);
    check("reset/zero", ZERO, 1'b1);
    check("reset/carry", CARRY, 1'b0);
    check("reset/busy", BUSY, 1'b0);
    check("reset/done", DONE, 1'b0);

    issue(A_ADD, S_SLL, 8'hF0, 8'h20, 8'h10, 1'b1); wait_done(0, "add_f0_20");   @(negedge CLK);
    issue(A_SUB, S_SLL, 8'h05, 8'h05, 8'h00, 1'b1); wait_done(0, "sub_eq");      @(negedge CLK);
    issue(A_SUB, S_SLL, 8'h03, 8'h05, 8'hFE, 1'b0); wait_done(0, "sub_borrow");  @(negedge CLK);
    issue(A_FWD, S_SLL, 8'hAA, 8'h5C, 8'h5C, 1'b0); wait_done(0, "fwd");         @(negedge CLK);
    issue(A_AND, S_SLL, 8'h3C, 8'hF0, 8'h30, 1'b0); wait_done(0, "and");         @(negedge CLK);
    issue(A_OR,  S_SLL, 8'h3C, 8'hC0, 8'hFC, 1'b0); wait_done(0, "or");          @(negedge CLK);
    issue(A_MUL, S_SLL, 8'd13, 8'd11, 8'h8F, 1'b0); wait_done(0, "mul_13_11");   @(negedge CLK);
    issue(A_MUL, S_SLL, 8'h10, 8'h10, 8'h00, 1'b0); wait_done(0, "mul_ovf");     @(negedge CLK);
    issue(A_SHF, S_SRA, 8'h90, 8'h03, 8'hF2, 1'b0); wait_done(0, "sra_90_3");    @(negedge CLK);
    issue(A_SHF, S_ROR, 8'h81, 8'h01, 8'hC0, 1'b0); wait_done(0, "ror_81_1");
    repeat (2) @(negedge CLK);
    check("hold/result", RESULT, 8'hC0);
    check("hold/done", DONE, 1'b0);
    issue(A_SHF, S_SLL, 8'h11, 8'h0B, 8'h88, 1'b0); wait_done(0, "sll_amt_0b");  @(negedge CLK);
    issue(A_SHF, S_SRL, 8'hF0, 8'h08, 8'hF0, 1'b0); wait_done(0, "srl_amt_0");   @(negedge CLK);
    issue(A_RSV, S_SLL, 8'hFF, 8'hFF, 8'h00, 1'b0); wait_done(0, "reserved");    @(negedge CLK);

    issue(A_MUL, S_SLL, 8'd13, 8'd11, 8'h8F, 1'b0); wait_done(1, "mul_ignore_start");
    @(negedge CLK);

    issue(A_MUL, S_SLL, 8'h07, 8'h09, 8'h3F, 1'b0); wait_done(0, "b2b_first");
    issue(A_ADD, S_SLL, 8'h40, 8'h02, 8'h42, 1'b0); wait_done(0, "b2b_second");
    @(negedge CLK);

    for (int i = 0; i < 16; i++) begin
      issue_model(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  8'($urandom), 8'($urandom));
      wait_done(0, $sformatf("rand_%0d", i));
      @(negedge CLK);
    end

    issue(A_ADD, S_SLL, 8'h01, 8'h02, 8'h03, 1'b0); wait_done(0, "pre_abort");   @(negedge CLK);
    issue(A_MUL, S_SLL, 8'd13, 8'd11, 8'h8F, 1'b0);
    repeat (3) @(negedge CLK);
    check("abort/busy_before", BUSY, 1'b1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    e_drop = exp_q.pop_front();
    check("abort/result", RESULT, 8'h00);
    check("abort/zero", ZERO, 1'b1);
    check("abort/busy", BUSY, 1'b0);
    check("abort/done", DONE, 1'b0);
    dn = 0;
    repeat (12) begin
      @(negedge CLK);
      if (DONE === 1'b1) dn++;
    end
    check("abort/no_late_done", dn, 0);
    $display("[TB] abort: dropped mul expecting %02h, result=%02h", e_drop.result, RESULT);

    RESET = 1'b1; START = 1'b1; ALUOP = A_ADD; DATA1 = 8'h01; DATA2 = 8'h01;
    @(negedge CLK);
    RESET = 1'b0; START = 1'b0;
    check("rst_start/done", DONE, 1'b0);
    check("rst_start/busy", BUSY, 1'b0);
    check("rst_start/result", RESULT, 8'h00);
    @(negedge CLK);
    check("rst_start/done_later", DONE, 1'b0);
    $display("[TB] rst_start: result=%02h done=%0b", RESULT, DONE);

    issue(A_ADD, S_SLL, 8'h7F, 8'h01, 8'h80, 1'b0); wait_done(0, "post_reset_add");
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, clocked successor to the single-cycle 8-bit ALU. It executes forward, add, subtract, AND, OR, shift/rotate and multiply on WIDTH-bit operands under a start/busy/done handshake. Simple ops finish in one cycle. Multiply, and shifts when fast-shift is disabled, iterate over several cycles. It sits in the CPU execute stage; the control unit stalls on BUSY and samples RESULT and flags when DONE is high.

## Interface
- WIDTH, 8: operand/result width; power of two, ≥4
- SHW, $clog2(WIDTH): shift-amount bits taken from DATA2 (derived, not overridden)
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  reset, synchronous, active-high
- START  input  1  request; accepted only when BUSY=0
- ALUOP  input  3  opcode, sampled with START
- SHIFTOP  input  2  shift sub-op, sampled with START: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- DATA1  input  WIDTH  operand A / shift source, sampled with START
- DATA2  input  WIDTH  operand B / shift amount (low SHW bits), sampled with START
- RESULT  output  WIDTH  registered result, held until next DONE
- ZERO  output  1  high when RESULT==0 (decoded from RESULT register)
- CARRY  output  1  add carry-out; sub no-borrow (DATA1≥DATA2 unsigned); 0 for other ops
- BUSY  output  1  high while a multi-cycle op is in progress
- DONE  output  1  one-cycle pulse; RESULT/ZERO/CARRY valid

## Operation
- Opcodes: 000 FORWARD (DATA2); 001 ADD; 010 AND; 011 OR; 100 SHIFT per SHIFTOP; 101 MUL (low WIDTH bits of product); 110 SUB (DATA1−DATA2); 111 reserved → RESULT 0, CARRY 0.
- ADD/SUB wrap modulo 2^WIDTH.
- Shift amount is DATA2[SHW-1:0]; higher DATA2 bits ignored. SRA replicates the MSB; ROR rotates right.
- FSM states:
  - IDLE: START=1 latches ALUOP, SHIFTOP, DATA1, DATA2. Single-cycle ops and zero-amount shifts → FIN. MUL and non-zero iterative shifts → RUN.
  - RUN: BUSY=1. Counter loaded with the iteration count and decremented each cycle. Last iteration → FIN.
  - FIN: RESULT/CARRY registered, DONE=1, BUSY=0. Returns to IDLE unless START=1, in which case the new request is accepted in this same cycle (back-to-back).
- MUL is shift-add, one multiplier bit per cycle, WIDTH iterations. The accumulator is WIDTH bits; overflow is discarded.
- Iterative shift moves one bit position per cycle, for amount iterations.
- START while BUSY=1 is ignored; the in-flight op is unaffected. Input changes after acceptance have no effect.
- Reset values: RESULT=0, ZERO=1, CARRY=0, BUSY=0, DONE=0, FSM=IDLE, counter=0.
- RESET mid-operation aborts the op with no DONE, and the reset values apply next cycle.
- RESET has priority over a simultaneous START.

## Timing
- START accepted at edge 0.
- Single-cycle ops: DONE high in cycle 1.
- Iterative shift by n>0: BUSY high cycles 1..n, DONE in cycle n+1. Amount 0: DONE in cycle 1.
- MUL: BUSY high cycles 1..WIDTH, DONE in cycle WIDTH+1.
- RESULT, ZERO and CARRY change only on the edge that raises DONE (or on reset).
- No combinational path from inputs to outputs.

## Configuration
- ALU_FAST_SHIFT_EN defined: SHIFT uses a combinational barrel shifter and always completes in one cycle (DONE in cycle 1, BUSY never raised).
- ALU_FAST_SHIFT_EN undefined: SHIFT iterates one position per cycle as above; no barrel shifter is instantiated.
- MUL timing is identical in both builds.

## Structure
- Shared package/header alu_defs holds:
  - ALUOP codes (OP_FWD, OP_ADD, OP_AND, OP_OR, OP_SHIFT, OP_MUL, OP_SUB)
  - SHIFTOP codes (SH_SLL, SH_SRL, SH_SRA, SH_ROR)
  - FSM state encodings (ST_IDLE, ST_RUN, ST_FIN)
- One sub-module: seq_multiplier (WIDTH-parametrised shift-add datapath with load/step/done).
- FSM, shift logic and flag generation stay in multicycle_alu.

## Test plan
- WIDTH=8, ADD 8'hF0+8'h20 → RESULT 8'h10, CARRY 1, ZERO 0, DONE in cycle 1; SUB 8'h05−8'h05 → RESULT 8'h00, ZERO 1, CARRY 1.
- MUL 8'd13×8'd11 → RESULT 8'h8F, BUSY cycles 1–8, DONE cycle 9. MUL 8'h10×8'h10 → RESULT 8'h00, ZERO 1.
- SHIFT SRA 8'h90 by 3 → 8'hF2: DONE cycle 4 without ALU_FAST_SHIFT_EN, cycle 1 with it. ROR 8'h81 by 1 → 8'hC0. DATA2=8'h0B shifts by 3.
- MUL in flight, START pulses with new operands at cycles 3 and 5 → ignored, original product returned. A START held during the DONE cycle → new op accepted back-to-back.
- RESET asserted at cycle 4 of a MUL → no DONE; next cycle RESULT 0, ZERO 1, BUSY 0. START and RESET together → request dropped.
- ALUOP 111 with DATA1=8'hFF, DATA2=8'hFF → RESULT 0, ZERO 1, CARRY 0, DONE cycle 1.
